// File: rtl/rsa_pkg.sv
// Shared RSA front-end types: packer state encoding and default widths.
// Also used by the FME side.
package rsa_pkg;
  localparam int KEY_W_DEF  = 32;
  localparam int BYTE_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, SIZING, PACK, ISSUE} state_t;
endpackage

// File: rtl/rsa_bitlen.sv
// Bit-length sizer: shifts a copy of the modulus right one bit per cycle and
// counts until it reaches zero. done marks the cycle the copy reaches zero.
module rsa_bitlen #(
  parameter int KEY_W = 32,
  parameter int LEN_W = $clog2(KEY_W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] key,
  output logic [LEN_W-1:0] n_len,
  output logic             done
);
  logic [KEY_W-1:0] key_buf;
  logic             run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_buf <= '0;
      n_len   <= '0;
      run     <= 1'b0;
    end else if (load) begin
      key_buf <= key;
      n_len   <= '0;
      run     <= 1'b1;
    end else if (run) begin
      if (key_buf != '0) begin
        n_len   <= n_len + LEN_W'(1);
        key_buf <= key_buf >> 1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign done = run && (key_buf == '0);
endmodule

// File: rtl/rsa_block_packer.sv
// RSA input stage: sizes modulus n, then packs bytes LSB-first into (L-1)-bit
// blocks with valid/ready hand-off. Define RSA_BLK_CNT_EN to add blk_cnt.
module rsa_block_packer
  import rsa_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int LEN_W  = $clog2(KEY_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  n_key,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ack,
  input  logic              eom,
  output logic [LEN_W-1:0]  n_len_out,
  output logic              sized,
  output logic              key_err,
  output logic              blk_valid,
  output logic [KEY_W-1:0]  blk_data,
  output logic              blk_last,
  input  logic              blk_ready,
  output logic              busy
`ifdef RSA_BLK_CNT_EN
  ,
  output logic [15:0]       blk_cnt
`endif
);
  localparam int IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  n_len, blk_b, bit_cnt, cnt_inc, sh_amt;
  logic              done;
  logic [KEY_W-1:0]  shreg;
  logic [BYTE_W-1:0] byte_buf;
  logic [IDX_W-1:0]  byte_idx;
  logic              buf_full, eom_pend, last_q;
  logic              eom_now, take, flush, shift_en, shift_bit;

  rsa_bitlen #(.KEY_W(KEY_W), .LEN_W(LEN_W)) u_bitlen (
    .clk  (clk),
    .rst  (rst),
    .load (start && (state == IDLE)),
    .key  (n_key),
    .n_len(n_len),
    .done (done)
  );

  assign n_len_out = n_len;
  assign blk_b     = n_len - LEN_W'(1);
  assign cnt_inc   = bit_cnt + LEN_W'(1);
  // Top bit_cnt positions of shreg hold the block; shifting by KEY_W-bit_cnt
  // right-aligns it and zero-fills everything above.
  assign sh_amt    = LEN_W'(KEY_W) - bit_cnt;

  always_comb begin
    state_nx  = state;
    eom_now   = eom_pend | eom;
    take      = (state == PACK) && !buf_full && byte_valid && !eom_now;
    flush     = (state == PACK) && !buf_full && eom_now;
    shift_en  = take || ((state == PACK) && buf_full);
    shift_bit = take ? byte_data[0] : byte_buf[byte_idx];
    byte_ack  = take;
    sized     = (state == SIZING) && done && (n_len >= LEN_W'(2));
    key_err   = (state == SIZING) && done && (n_len <  LEN_W'(2));
    busy      = (state != IDLE);
    blk_valid = (state == ISSUE);
    blk_last  = (state == ISSUE) && last_q;
    blk_data  = (state == ISSUE) ? (shreg >> sh_amt) : '0;
    case (state)
      IDLE:   if (start) state_nx = SIZING;
      SIZING: if (done) state_nx = (n_len >= LEN_W'(2)) ? PACK : IDLE;
      PACK:   if (flush || (shift_en && cnt_inc == blk_b)) state_nx = ISSUE;
      ISSUE:  if (blk_ready) state_nx = last_q ? IDLE : PACK;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_buf <= '0;
      byte_idx <= '0;
      buf_full <= 1'b0;
      eom_pend <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) eom_pend <= 1'b0;
      else if (eom)      eom_pend <= 1'b1;
      case (state)
        IDLE: last_q <= 1'b0;
        SIZING:
          if (done) begin
            bit_cnt  <= '0;
            byte_idx <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
          end
        PACK:
          if (flush) begin
            last_q   <= 1'b1;
            eom_pend <= 1'b0;
          end else if (shift_en) begin
            shreg   <= {shift_bit, shreg[KEY_W-1:1]};
            bit_cnt <= cnt_inc;
            if (take) begin
              byte_buf <= byte_data;
              byte_idx <= IDX_W'(1);
              buf_full <= (BYTE_W > 1);
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              if (byte_idx == IDX_W'(BYTE_W-1)) buf_full <= 1'b0;
            end
          end
        ISSUE: if (blk_ready) bit_cnt <= '0;
        default: ;
      endcase
    end
  end

`ifdef RSA_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      blk_cnt <= '0;
    else if (state == IDLE && start)
      blk_cnt <= '0;
    else if (state == ISSUE && blk_ready && blk_cnt != 16'hFFFF)
      blk_cnt <= blk_cnt + 16'd1;
  end
`endif
endmodule
